// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter that lets NUM_REQ requesters share one async_fifo write port.
// Each grant moves up to MAX_BURST beats and is released early when the owner drops valid.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_a,
  input  logic                          rst_a,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_n;
  logic [GW-1:0]         grant_n, last_grant, last_n, cand, rr_pick;
  logic [CW-1:0]         beat_cnt, cnt_n;
  logic                  rr_found, armed, write;
  logic [DATA_WIDTH-1:0] slot [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk_a or negedge rst_a) begin
    if (!rst_a) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk_a or negedge rst_a) begin
    if (!rst_a) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
      beat_cnt   <= cnt_n;
    end
  end

  // Search starts just past the last owner, so the previous winner has lowest priority.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant_id;
    last_n  = last_grant;
    cnt_n   = beat_cnt;
    write   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && rr_found) begin
          state_n = GRANT;
          grant_n = rr_pick;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        write = req_valid[grant_id] && !fifo_full;
        if (write) begin
          cnt_n = beat_cnt + 1'b1;
          if (cnt_n == CW'(MAX_BURST)) begin
            state_n = IDLE;
            last_n  = grant_id;
          end
        end else if (!req_valid[grant_id]) begin
          state_n = IDLE;
          last_n  = grant_id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == GRANT);
    fifo_wr_en = write;
    fifo_din   = slot[grant_id];
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = write && (grant_id == GW'(i));
    end
  end

endmodule
